// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a 4-bit character FIFO, sending each nibble as an ASCII hex
// character on an 8N1 UART line (LSB first).
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   start      - one-cycle drain request, honoured only when idle
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO read data, valid the cycle after fifo_re
//   fifo_re    - FIFO read enable (single-cycle pulses)
//   tx         - UART serial output, idle high
//   busy       - high from start acceptance until return to idle
//   done       - one-cycle pulse on the final return to idle
//
// Optional feature: define FIFO_UART_TX_CRLF_EN to append a CR/LF line
// terminator after the FIFO has been drained.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fifo_empty,
    input  logic [3:0] fifo_data,
    output logic       fifo_re,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_CRLF_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP, S_EOL} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;
    logic          pop;
`ifdef FIFO_UART_TX_CRLF_EN
    // Number of terminator characters already loaded: 0 none, 1 CR, 2 CR+LF.
    logic [1:0]    eol_q, eol_d;
`endif

    assign bit_end = baud_q == BAUD_LAST;
    // Combinational so the pop lands in the REQ cycle itself and can never
    // coincide with an empty FIFO.
`ifdef FIFO_UART_TX_CRLF_EN
    assign pop = state_q == S_REQ && !fifo_empty && eol_q == 2'd0;
`else
    assign pop = state_q == S_REQ && !fifo_empty;
`endif
    assign fifo_re = pop;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FIFO_UART_TX_CRLF_EN
        eol_d   = eol_q;
`endif
        // Counts only while a bit is on the line; every other state holds it at
        // zero, so each bit-timing state is entered with a fresh count.
        baud_d  = (state_q inside {S_START, S_DATA, S_STOP}) && !bit_end ? baud_q + 1'b1 : '0;
        case (state_q)
            S_IDLE: begin
`ifdef FIFO_UART_TX_CRLF_EN
                eol_d = 2'd0;
`endif
                if (start) begin
                    state_d = S_REQ;
                    busy_d  = 1'b1;
                end
            end
            S_REQ: begin
`ifdef FIFO_UART_TX_CRLF_EN
                if (pop) state_d = S_WAIT;
                else if (eol_q == 2'd2) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                else state_d = S_EOL;
`else
                if (pop) state_d = S_WAIT;
                else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
`endif
            end
            S_WAIT: begin
                shift_d = fifo_data < 4'd10 ? 8'h30 + {4'h0, fifo_data} : 8'h37 + {4'h0, fifo_data};
                tx_d    = 1'b0;
                state_d = S_START;
            end
`ifdef FIFO_UART_TX_CRLF_EN
            S_EOL: begin
                shift_d = eol_q == 2'd0 ? 8'h0D : 8'h0A;
                eol_d   = eol_q + 2'd1;
                tx_d    = 1'b0;
                state_d = S_START;
            end
`endif
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
                    else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIFO_UART_TX_CRLF_EN
            eol_q   <= '0;
`endif
        end
        else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIFO_UART_TX_CRLF_EN
            eol_q   <= eol_d;
`endif
        end
    end
endmodule
